// File: rtl/instr_fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
// Entry layout is {fault_tag, pc, inst}; state encoding is RUN/FAULT.
package instr_fetch_queue_pkg;

  localparam int IQ_INST_WIDTH = 32;
  localparam int IQ_ADDR_WIDTH = 64;
  localparam int IQ_PC_INC     = 4;

  typedef enum logic {
    IQ_RUN   = 1'b0,
    IQ_FAULT = 1'b1
  } iq_state_e;

  typedef struct packed {
    logic                     fault;
    logic [IQ_ADDR_WIDTH-1:0] pc;
    logic [IQ_INST_WIDTH-1:0] inst;
  } iq_entry_t;

endpackage

// File: rtl/instr_fetch_queue_ring_ram.sv
// Circular entry storage with FETCH_W wrapping write ports
// and ISSUE_W wrapping read ports.
module iq_ring_ram #(
  parameter int DEPTH   = 8,
  parameter int W       = 97,
  parameter int FETCH_W = 2,
  parameter int ISSUE_W = 2,
  localparam int PW     = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic [FETCH_W-1:0]   wen_i,
  input  logic [PW-1:0]        wr_ptr_i,
  input  logic [FETCH_W*W-1:0] wdata_i,
  input  logic [PW-1:0]        rd_ptr_i,
  output logic [ISSUE_W*W-1:0] rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  // Pointer arithmetic wraps naturally since DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    for (int k = 0; k < FETCH_W; k++) begin
      if (wen_i[k]) begin
        mem_q[wr_ptr_i + PW'(k)] <= wdata_i[k*W +: W];
      end
    end
  end

  always_comb begin
    rdata_o = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      rdata_o[k*W +: W] = mem_q[rd_ptr_i + PW'(k)];
    end
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction-granular fetch queue between IFU and decode.
// Optional same-cycle bypass: define INSTR_FETCH_QUEUE_BYPASS_EN.
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int INST_WIDTH = IQ_INST_WIDTH,
  parameter int ADDR_WIDTH = IQ_ADDR_WIDTH,
  parameter int DEPTH      = 8,
  parameter int FETCH_W    = 2,
  parameter int ISSUE_W    = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [FETCH_W*INST_WIDTH-1:0] inst_i,
  input  logic [$clog2(FETCH_W+1)-1:0]  inst_cnt_i,
  input  logic [ADDR_WIDTH-1:0]         pc_i,
  input  logic                          inst_valid_i,
  input  logic                          misaligned_exception_i,
  input  logic [ADDR_WIDTH-1:0]         misaligned_addr_i,
  input  logic                          ifu_flush_i,
  input  logic [$clog2(ISSUE_W+1)-1:0]  decode_accept_i,
  output logic                          instr_queue_ready_o,
  output logic [ISSUE_W*INST_WIDTH-1:0] inst_o,
  output logic [ISSUE_W*ADDR_WIDTH-1:0] pc_o,
  output logic [ISSUE_W-1:0]            inst_valid_o,
  output logic                          misaligned_exception_o,
  output logic                          misaligned_addr_valid_o,
  output logic [ADDR_WIDTH-1:0]         misaligned_addr_bypass_o,
  output logic [$clog2(DEPTH):0]        count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = 1 + ADDR_WIDTH + INST_WIDTH;

  iq_state_e             state_q, state_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  addr_vld_q, addr_vld_d;

  logic                  ready, enq_fire, fault_enq, bypass;
  logic                  seen_fault, head_fault;
  logic [CW-1:0]         n_enq, n_wr, n_deq, n_avail;
  logic [CW-1:0]         rd_adv, skip;
  logic [FETCH_W-1:0]    wen;
  logic [FETCH_W*EW-1:0] in_ent, wdata;
  logic [ISSUE_W*EW-1:0] rdata, out_ent;
  logic [ISSUE_W-1:0]    vld;

  assign ready = (CW'(DEPTH) - count_q >= CW'(FETCH_W))
              && (state_q == IQ_RUN);
  assign enq_fire  = inst_valid_i && ready && !ifu_flush_i;
  assign fault_enq = enq_fire && misaligned_exception_i;

`ifdef INSTR_FETCH_QUEUE_BYPASS_EN
  assign bypass = !rst && enq_fire && !misaligned_exception_i
               && (count_q == '0) && (state_q == IQ_RUN);
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    n_enq = '0;
    if (enq_fire) begin
      if (misaligned_exception_i) begin
        n_enq = CW'(1);
      end else if (int'(inst_cnt_i) > FETCH_W) begin
        n_enq = CW'(FETCH_W);
      end else begin
        n_enq = CW'(inst_cnt_i);
      end
    end
  end

  always_comb begin
    in_ent = '0;
    for (int s = 0; s < FETCH_W; s++) begin
      in_ent[s*EW +: EW] = {1'b0,
        pc_i + ADDR_WIDTH'(IQ_PC_INC * s),
        inst_i[s*INST_WIDTH +: INST_WIDTH]};
    end
  end

  // Bypassed slots consumed this cycle are skipped on the write side.
  assign skip   = bypass ? n_deq : '0;
  assign n_wr   = n_enq - skip;
  assign rd_adv = bypass ? '0 : n_deq;

  always_comb begin
    wdata = '0;
    wen   = '0;
    for (int k = 0; k < FETCH_W; k++) begin
      wen[k] = k < int'(n_wr);
      for (int s = 0; s < FETCH_W; s++) begin
        if (s == k + int'(skip)) begin
          wdata[k*EW +: EW] = in_ent[s*EW +: EW];
        end
      end
    end
    if (fault_enq) begin
      wdata[0 +: EW] = {1'b1, pc_i, {INST_WIDTH{1'b0}}};
    end
  end

  iq_ring_ram #(
    .DEPTH   (DEPTH),
    .W       (EW),
    .FETCH_W (FETCH_W),
    .ISSUE_W (ISSUE_W)
  ) u_ram (
    .clk      (clk),
    .wen_i    (wen),
    .wr_ptr_i (wr_ptr_q),
    .wdata_i  (wdata),
    .rd_ptr_i (rd_ptr_q),
    .rdata_o  (rdata)
  );

  // A fault entry is only presented at the head; it fences younger slots.
  always_comb begin
    vld        = '0;
    n_avail    = '0;
    out_ent    = '0;
    seen_fault = 1'b0;
    for (int k = 0; k < ISSUE_W; k++) begin
      if (!seen_fault && k < int'(count_q)
          && !(k > 0 && rdata[k*EW+EW-1])) begin
        vld[k]               = 1'b1;
        out_ent[k*EW +: EW]  = rdata[k*EW +: EW];
        n_avail              = n_avail + CW'(1);
      end
      if (k < int'(count_q)) begin
        seen_fault = seen_fault | rdata[k*EW+EW-1];
      end
    end
    head_fault = vld[0] & rdata[EW-1];
    if (bypass) begin
      vld        = '0;
      n_avail    = '0;
      out_ent    = '0;
      head_fault = 1'b0;
      for (int k = 0; k < ISSUE_W && k < FETCH_W; k++) begin
        if (k < int'(n_enq)) begin
          vld[k]              = 1'b1;
          out_ent[k*EW +: EW] = in_ent[k*EW +: EW];
          n_avail             = n_avail + CW'(1);
        end
      end
    end
  end

  assign n_deq = (CW'(decode_accept_i) > n_avail) ? n_avail
                                                  : CW'(decode_accept_i);

  always_comb begin
    inst_o = '0;
    pc_o   = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      inst_o[k*INST_WIDTH +: INST_WIDTH] =
        out_ent[k*EW +: INST_WIDTH];
      pc_o[k*ADDR_WIDTH +: ADDR_WIDTH] =
        out_ent[k*EW + INST_WIDTH +: ADDR_WIDTH];
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q + PW'(n_wr);
    rd_ptr_d   = rd_ptr_q + PW'(rd_adv);
    count_d    = count_q + n_wr - rd_adv;
    addr_d     = addr_q;
    addr_vld_d = addr_vld_q;
    if (fault_enq) begin
      state_d    = IQ_FAULT;
      addr_d     = misaligned_addr_i;
      addr_vld_d = 1'b1;
    end
    if (ifu_flush_i) begin
      state_d    = IQ_RUN;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      addr_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IQ_RUN;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      addr_q     <= '0;
      addr_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      addr_q     <= addr_d;
      addr_vld_q <= addr_vld_d;
    end
  end

  assign instr_queue_ready_o      = ready;
  assign inst_valid_o             = vld;
  assign misaligned_exception_o   = head_fault;
  assign misaligned_addr_valid_o  = addr_vld_q;
  assign misaligned_addr_bypass_o = addr_q;
  assign count_o                  = count_q;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed self-checking bench for instr_fetch_queue
// (default build, same-cycle bypass disabled).
module tb_instr_fetch_queue;

  localparam int IW = 32;
  localparam int AW = 64;
  localparam int FW = 2;
  localparam int IS = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [FW*IW-1:0] inst_i;
  logic [1:0]       cnt_i;
  logic [AW-1:0]    pc_i;
  logic             vld_i;
  logic             exc_i;
  logic [AW-1:0]    maddr_i;
  logic             flush_i;
  logic [1:0]       acc_i;
  logic             rdy_o;
  logic [IS*IW-1:0] inst_o;
  logic [IS*AW-1:0] pc_o;
  logic [IS-1:0]    vld_o;
  logic             exc_o;
  logic             av_o;
  logic [AW-1:0]    byp_o;
  logic [3:0]       cnt_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instr_fetch_queue dut (
    .clk                      (clk),
    .rst                      (rst),
    .inst_i                   (inst_i),
    .inst_cnt_i               (cnt_i),
    .pc_i                     (pc_i),
    .inst_valid_i             (vld_i),
    .misaligned_exception_i   (exc_i),
    .misaligned_addr_i        (maddr_i),
    .ifu_flush_i              (flush_i),
    .decode_accept_i          (acc_i),
    .instr_queue_ready_o      (rdy_o),
    .inst_o                   (inst_o),
    .pc_o                     (pc_o),
    .inst_valid_o             (vld_o),
    .misaligned_exception_o   (exc_o),
    .misaligned_addr_valid_o  (av_o),
    .misaligned_addr_bypass_o (byp_o),
    .count_o                  (cnt_o)
  );

  task automatic check(string tag, logic [127:0] got,
                       logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    vld_i   = 1'b0;
    exc_i   = 1'b0;
    flush_i = 1'b0;
    acc_i   = '0;
    cnt_i   = '0;
    inst_i  = '0;
    pc_i    = '0;
    maddr_i = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic push(logic [31:0] i1, logic [31:0] i0,
                      logic [1:0] c, logic [63:0] pc);
    vld_i  = 1'b1;
    inst_i = {i1, i0};
    cnt_i  = c;
    pc_i   = pc;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cnt", cnt_o, 0);
    check("rst_vld", vld_o, 0);
    check("rst_rdy", rdy_o, 1);
    check("rst_exc", exc_o, 0);
    check("rst_av", av_o, 0);
    check("rst_inst", inst_o, 0);
    check("rst_pc", pc_o, 0);
    check("rst_byp", byp_o, 0);
    rst = 1'b0;

    push(32'hCAFEBABE, 32'hDEADBEEF, 2, 64'h1000);
    tick();
    check("p1_vld", vld_o, 2'b11);
    check("p1_inst", inst_o, 64'hCAFEBABE_DEADBEEF);
    check("p1_pc", pc_o, {64'h1004, 64'h1000});
    check("p1_cnt", cnt_o, 2);

    push(32'h11, 32'h10, 2, 64'h1008); tick();
    push(32'h13, 32'h12, 2, 64'h1010); tick();
    push(32'h15, 32'h14, 2, 64'h1018); tick();
    check("full_cnt", cnt_o, 8);
    check("full_rdy", rdy_o, 0);
    push(32'h99, 32'h98, 2, 64'h9000); tick();
    check("full_drop", cnt_o, 8);

    acc_i = 1; tick();
    check("d1_cnt", cnt_o, 7);
    check("d1_head", inst_o[31:0], 32'hCAFEBABE);
    check("d1_rdy", rdy_o, 0);
    acc_i = 1; tick();
    check("d2_cnt", cnt_o, 6);
    check("d2_rdy", rdy_o, 1);
    acc_i = 1; tick();
    acc_i = 1; tick();
    check("d4_cnt", cnt_o, 4);
    check("d4_inst", inst_o, {32'h13, 32'h12});
    check("d4_pc", pc_o, {64'h1014, 64'h1010});
    acc_i = 1; tick();
    check("d5_cnt", cnt_o, 3);

    // enqueue across the pointer wrap while consuming one
    push(32'h21, 32'h20, 2, 64'h2000);
    acc_i = 1; tick();
    check("pc_cnt", cnt_o, 4);
    check("pc_inst", inst_o, {32'h15, 32'h14});
    acc_i = 2; tick();
    check("wrap_cnt", cnt_o, 2);
    check("wrap_inst", inst_o, {32'h21, 32'h20});
    check("wrap_pc", pc_o, {64'h2004, 64'h2000});
    acc_i = 3; tick();
    check("over_cnt", cnt_o, 0);
    check("over_vld", vld_o, 0);
    acc_i = 2; tick();
    check("empty_cnt", cnt_o, 0);
    check("empty_inst", inst_o, 0);

    push(32'h31, 32'h30, 3, 64'h3000); tick();
    check("clip_cnt", cnt_o, 2);
    check("clip_inst", inst_o, {32'h31, 32'h30});
    push(32'h33, 32'h32, 0, 64'h3100); tick();
    check("zero_cnt", cnt_o, 2);
    acc_i = 2; tick();

    push(32'h41, 32'h40, 2, 64'h4000); tick();
    push(32'h0, 32'h0, 2, 64'h4008);
    exc_i   = 1'b1;
    maddr_i = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    check("f_cnt", cnt_o, 3);
    check("f_rdy", rdy_o, 0);
    check("f_vld", vld_o, 2'b11);
    check("f_inst", inst_o, {32'h41, 32'h40});
    check("f_exc", exc_o, 0);
    check("f_av", av_o, 1);
    check("f_byp", byp_o, 64'hFFFF_FFFF_FFFF_FFFC);
    push(32'h51, 32'h50, 2, 64'h5000); tick();
    check("f_drop", cnt_o, 3);
    acc_i = 2; tick();
    check("fh_cnt", cnt_o, 1);
    check("fh_vld", vld_o, 2'b01);
    check("fh_exc", exc_o, 1);
    check("fh_pc", pc_o, {64'h0, 64'h4008});
    check("fh_inst", inst_o, 0);
    acc_i = 1; tick();
    check("fe_cnt", cnt_o, 0);
    check("fe_exc", exc_o, 0);
    check("fe_av", av_o, 1);
    check("fe_rdy", rdy_o, 0);
    flush_i = 1'b1; tick();
    check("ff_rdy", rdy_o, 1);
    check("ff_av", av_o, 0);

    push(32'h0, 32'h60, 1, 64'h6000); tick();
    push(32'h0, 32'h0, 1, 64'h6004);
    exc_i   = 1'b1;
    maddr_i = 64'h6006;
    tick();
    check("fb_cnt", cnt_o, 2);
    check("fb_vld", vld_o, 2'b01);
    check("fb_exc", exc_o, 0);
    check("fb_byp", byp_o, 64'h6006);
    push(32'h71, 32'h70, 2, 64'h7000);
    acc_i   = 2;
    flush_i = 1'b1;
    tick();
    check("fbf_cnt", cnt_o, 0);
    check("fbf_av", av_o, 0);
    check("fbf_rdy", rdy_o, 1);

    push(32'h81, 32'h80, 2, 64'h8000); tick();
    push(32'h83, 32'h82, 2, 64'h8008); tick();
    push(32'h0, 32'h84, 1, 64'h8010); tick();
    check("fl5_cnt", cnt_o, 5);
    push(32'h91, 32'h90, 2, 64'h9000);
    acc_i   = 2;
    flush_i = 1'b1;
    tick();
    check("fl_cnt", cnt_o, 0);
    check("fl_vld", vld_o, 0);
    check("fl_rdy", rdy_o, 1);

    push(32'hA1, 32'hA0, 2, 64'hA000); tick();
    check("mr_pre", cnt_o, 2);
    #2 rst = 1'b1;
    #1;
    check("mr_cnt", cnt_o, 0);
    check("mr_vld", vld_o, 0);
    check("mr_rdy", rdy_o, 1);
    check("mr_inst", inst_o, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    push(32'hB1, 32'hB0, 2, 64'hB000); tick();
    check("post_inst", inst_o, {32'hB1, 32'hB0});
    check("post_pc", pc_o, {64'hB004, 64'hB000});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Parametrised successor to the IFU instruction queue: an instruction-granular circular buffer between the fetch unit and decode.
- Accepts up to FETCH_W instructions per cycle, each with a PC.
- Presents up to ISSUE_W oldest instructions per cycle; decode consumes a variable count.
- Carries one pending misaligned-fetch exception in order with the instruction stream; flush empties the queue on redirect.

Parameters:
- INST_WIDTH, 32, instruction width in bits.
- ADDR_WIDTH, 64, PC / fault-address width.
- DEPTH, 8, storage slots in instructions; power of 2, DEPTH >= FETCH_W.
- FETCH_W, 2, max instructions enqueued per cycle.
- ISSUE_W, 2, max instructions presented per cycle.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- inst_i  in  FETCH_W*INST_WIDTH  fetched instructions; slot k = bits [k*INST_WIDTH +: INST_WIDTH]
- inst_cnt_i  in  $clog2(FETCH_W+1)  number of valid slots, contiguous from slot 0
- pc_i  in  ADDR_WIDTH  PC of slot 0; slot k PC = pc_i + 4*k
- inst_valid_i  in  1  enqueue request
- misaligned_exception_i  in  1  fetch fault on this request
- misaligned_addr_i  in  ADDR_WIDTH  faulting address
- ifu_flush_i  in  1  discard all contents
- decode_accept_i  in  $clog2(ISSUE_W+1)  instructions consumed this cycle
- instr_queue_ready_o  out  1  free slots >= FETCH_W and no fault pending
- inst_o  out  ISSUE_W*INST_WIDTH  oldest instructions, slot 0 oldest
- pc_o  out  ISSUE_W*ADDR_WIDTH  per-slot PC
- inst_valid_o  out  ISSUE_W  per-slot valid mask, contiguous from bit 0
- misaligned_exception_o  out  1  fault entry at head (slot 0)
- misaligned_addr_valid_o  out  1  misaligned_addr_bypass_o holds a valid address
- misaligned_addr_bypass_o  out  ADDR_WIDTH  latched fault address
- count_o  out  $clog2(DEPTH)+1  occupied slots

Behaviour:
- Reset (async, rst=1):
  - Pointers and count = 0; state = RUN.
  - inst_valid_o = 0, misaligned_exception_o = 0, misaligned_addr_valid_o = 0; address/data/PC outputs = 0.
  - instr_queue_ready_o = 1.
  - Reset mid-operation discards everything immediately.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; multi-slot writes and reads wrap across the DEPTH-1 -> 0 boundary.
- Enqueue fires when inst_valid_i && instr_queue_ready_o && !ifu_flush_i.
  - Normal request: writes inst_cnt_i slots at wr_ptr.
  - inst_cnt_i = 0 is a no-op.
  - inst_cnt_i > FETCH_W is clipped to FETCH_W.
- Fault enqueue (misaligned_exception_i with enqueue firing):
  - Writes exactly one fault-tagged slot (instruction = 0, PC = pc_i); inst_cnt_i is ignored.
  - misaligned_addr_i is latched into the address register; misaligned_addr_valid_o = 1 from the next cycle.
  - State -> FAULT.
- Outputs are combinational from storage: slot k valid iff k < count and no fault-tagged entry precedes it.
  - Fault entry at head: only slot 0 is valid, misaligned_exception_o = 1.
  - Fault entry behind normal entries: slots stop before it.
- Dequeue: removes min(decode_accept_i, popcount(inst_valid_o)); excess is ignored, never underflows.
- Simultaneous enqueue + dequeue: count_next = count + n_enq - n_deq; both take effect in the same edge.
- Full boundary: ready = (DEPTH - count >= FETCH_W) && state == RUN, so ready drops before overflow is possible.
- Empty boundary: inst_valid_o = 0; decode_accept_i is ignored.
- State machine:
  - RUN -> FAULT on fault enqueue.
  - FAULT -> RUN only on ifu_flush_i.
  - In FAULT, ready = 0. The fault entry can still be dequeued; the address stays valid until flush.
- ifu_flush_i has the highest priority over enqueue and dequeue in the same cycle. At the next edge:
  - count = 0, pointers = 0, state = RUN;
  - misaligned_addr_valid_o = 0.
- Latency: instruction enqueued at edge N is visible on the outputs after edge N (zero extra cycles).

Optional Feature:
- Macro: INSTR_FETCH_QUEUE_BYPASS_EN.
- Defined: when count == 0, state == RUN, and a normal enqueue fires:
  - Incoming slots are driven combinationally onto the outputs in the same cycle.
  - Slots accepted by decode_accept_i that cycle are not written into storage; the rest are stored.
  - Fault requests never bypass.
- Undefined: minimum enqueue-to-output latency is one edge.

Decomposition:
- Shared header/package holds:
  - INST_WIDTH and ADDR_WIDTH defaults;
  - the RUN/FAULT state encoding;
  - the PC increment constant (4);
  - the stored-entry layout {fault_tag, pc, inst}.
- One natural sub-module: iq_ring_ram, DEPTH-slot storage with FETCH_W wrapping write ports and ISSUE_W wrapping read ports.
- Pointer, count and FSM logic stay in the top level.

Test Plan:
- Reset, then enqueue inst_i = {CAFEBABE, DEADBEEF}, cnt = 2, pc = 0x1000 -> next cycle inst_valid_o = 2'b11, slot 0 = DEADBEEF at PC 0x1000, slot 1 = CAFEBABE at 0x1004, count_o = 2.
- Fill with four cnt = 2 pushes and accept = 0 -> count_o = 8, ready = 0. Then accept = 1 for 4 cycles -> ready returns once count <= 6; ordering preserved across the pointer wrap.
- Partial consume: count = 3, accept = 1 while enqueuing cnt = 2 -> count_o = 4; the head advances by exactly one.
- Fault: enqueue 2 normal instructions, then a fault at misaligned_addr_i = 0xFFFF_FFFF_FFFF_FFFC -> ready = 0. Slots present only the 2 normal instructions; after accept = 2, slot 0 shows misaligned_exception_o = 1, addr valid, bypass = ...FFFC.
- Flush with count = 5 while inst_valid_i = 1 and accept = 2 -> next cycle count = 0, inst_valid_o = 0, addr_valid = 0, ready = 1; the input is dropped.
- Assert rst mid-fill -> all outputs go to their reset values without waiting for a clock edge. With BYPASS_EN defined, enqueue into an empty queue is visible in the same cycle.
